// File: rtl/cle_label_stats.sv
// Label statistics stage: scans the label SRAM, accumulates per-label area (and bounding
// box when CLE_STATS_BBOX_EN is defined), then streams one record per non-empty label.
module cle_label_stats #(
    parameter int NUM_LABELS = 15,
    parameter int IMG_W      = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic [9:0]  sram_a,
    input  logic [7:0]  sram_q,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_label,
    output logic [10:0] out_area,
    output logic [4:0]  out_xmin,
    output logic [4:0]  out_xmax,
    output logic [4:0]  out_ymin,
    output logic [4:0]  out_ymax,
    output logic        busy,
    output logic        done,
    output logic        overflow
);
    localparam logic [9:0] LAST_A = 10'(IMG_W * IMG_W - 1);
    localparam logic [8:0] LAST_L = 9'(NUM_LABELS);

    typedef enum logic [2:0] {IDLE, SCAN, DRAIN, EMIT, DONE} state_t;
    state_t state, state_nx;

    logic        beat_vld;
    logic        beat_hit;
    logic        run_start;
    logic        emit_free;
    logic        emit_eval;
    logic        emit_load;
    logic [8:0]  ptr;
    logic [10:0] area [1:NUM_LABELS];
    logic [10:0] sel_area;

    assign run_start = (state == IDLE) && start;
    assign emit_free = ~out_valid | out_ready;
    assign emit_eval = ((state == DRAIN) || (state == EMIT)) && emit_free && (ptr <= LAST_L);
    assign beat_hit  = beat_vld && ({1'b0, sram_q} == ptr);
    assign emit_load = emit_eval && (sel_area != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = SCAN;
            SCAN:    if (sram_a == LAST_A) state_nx = DRAIN;
            DRAIN:   state_nx = EMIT;
            EMIT:    if (emit_free && (ptr > LAST_L)) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Label 1 is evaluated on the DRAIN edge, so the in-flight last beat is folded in here.
    always_comb begin
        sel_area = '0;
        for (int i = 1; i <= NUM_LABELS; i++) begin
            if (ptr == 9'(i)) sel_area = area[i];
        end
        if (beat_hit) sel_area = sel_area + 11'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sram_a    <= '0;
            beat_vld  <= 1'b0;
            ptr       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            overflow  <= 1'b0;
            out_valid <= 1'b0;
            out_label <= '0;
            out_area  <= '0;
        end else begin
            busy     <= (state_nx != IDLE);
            done     <= (state_nx == DONE);
            beat_vld <= (state == SCAN);
            if (run_start) begin
                sram_a   <= '0;
                ptr      <= 9'd1;
                overflow <= 1'b0;
            end else if (state == SCAN) begin
                sram_a <= sram_a + 10'd1;
            end
            if (beat_vld && (sram_q > 8'(NUM_LABELS))) overflow <= 1'b1;
            if (emit_eval) begin
                ptr       <= ptr + 9'd1;
                out_valid <= emit_load;
                if (emit_load) begin
                    out_label <= ptr[7:0];
                    out_area  <= sel_area;
                end
            end else if (emit_free) begin
                out_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 1; i <= NUM_LABELS; i++) begin
            if (run_start) begin
                area[i] <= '0;
            end else if (beat_vld && (sram_q == 8'(i))) begin
                area[i] <= area[i] + 11'd1;
            end
        end
    end

`ifdef CLE_STATS_BBOX_EN
    localparam int CW = $clog2(IMG_W);

    logic [4:0] tag_x, tag_y;
    logic [4:0] xmin [1:NUM_LABELS];
    logic [4:0] xmax [1:NUM_LABELS];
    logic [4:0] ymin [1:NUM_LABELS];
    logic [4:0] ymax [1:NUM_LABELS];
    logic [4:0] sel_xmin, sel_xmax, sel_ymin, sel_ymax;

    // Each beat carries the coordinates of the address issued one cycle before it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tag_x    <= '0;
            tag_y    <= '0;
            out_xmin <= '0;
            out_xmax <= '0;
            out_ymin <= '0;
            out_ymax <= '0;
        end else begin
            tag_x <= 5'(sram_a[CW-1:0]);
            tag_y <= 5'(sram_a >> CW);
            if (emit_load) begin
                out_xmin <= sel_xmin;
                out_xmax <= sel_xmax;
                out_ymin <= sel_ymin;
                out_ymax <= sel_ymax;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 1; i <= NUM_LABELS; i++) begin
            if (run_start) begin
                xmin[i] <= 5'(IMG_W - 1);
                xmax[i] <= '0;
                ymin[i] <= 5'(IMG_W - 1);
                ymax[i] <= '0;
            end else if (beat_vld && (sram_q == 8'(i))) begin
                if (tag_x < xmin[i]) xmin[i] <= tag_x;
                if (tag_x > xmax[i]) xmax[i] <= tag_x;
                if (tag_y < ymin[i]) ymin[i] <= tag_y;
                if (tag_y > ymax[i]) ymax[i] <= tag_y;
            end
        end
    end

    always_comb begin
        sel_xmin = 5'(IMG_W - 1);
        sel_xmax = '0;
        sel_ymin = 5'(IMG_W - 1);
        sel_ymax = '0;
        for (int i = 1; i <= NUM_LABELS; i++) begin
            if (ptr == 9'(i)) begin
                sel_xmin = xmin[i];
                sel_xmax = xmax[i];
                sel_ymin = ymin[i];
                sel_ymax = ymax[i];
            end
        end
        if (beat_hit) begin
            if (tag_x < sel_xmin) sel_xmin = tag_x;
            if (tag_x > sel_xmax) sel_xmax = tag_x;
            if (tag_y < sel_ymin) sel_ymin = tag_y;
            if (tag_y > sel_ymax) sel_ymax = tag_y;
        end
    end
`else
    assign out_xmin = '0;
    assign out_xmax = '0;
    assign out_ymin = '0;
    assign out_ymax = '0;
`endif

endmodule

// File: tb/tb_cle_label_stats.sv
// Scoreboard bench for cle_label_stats: a behavioural label SRAM plus a reference model
// that pushes the expected record stream before each run.
module tb_cle_label_stats;
    localparam int NUM_LABELS = 15;
    localparam int LAST_CYC   = 1025 + NUM_LABELS;

    typedef struct packed {
        logic [7:0]  label;
        logic [10:0] area;
        logic [4:0]  xmin;
        logic [4:0]  xmax;
        logic [4:0]  ymin;
        logic [4:0]  ymax;
    } rec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [9:0]  sram_a;
    logic [7:0]  sram_q = 8'd0;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_label;
    logic [10:0] out_area;
    logic [4:0]  out_xmin, out_xmax, out_ymin, out_ymax;
    logic        busy, done, overflow;

    logic [7:0] mem [0:1023];
    rec_t       sb[$];
    int         checks = 0;
    int         errors = 0;

    cle_label_stats #(.NUM_LABELS(NUM_LABELS), .IMG_W(32)) dut (
        .clk(clk), .reset(reset), .start(start),
        .sram_a(sram_a), .sram_q(sram_q),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_label(out_label), .out_area(out_area),
        .out_xmin(out_xmin), .out_xmax(out_xmax),
        .out_ymin(out_ymin), .out_ymax(out_ymax),
        .busy(busy), .done(done), .overflow(overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) sram_q <= mem[sram_a];

    task automatic fill_map(input logic [7:0] v);
        for (int a = 0; a < 1024; a++) mem[a] = v;
    endtask

    // Reference model: derive the expected record stream and overflow flag from the map.
    task automatic build_expected(output logic exp_ovf);
        int ar [1:NUM_LABELS];
        int x0 [1:NUM_LABELS];
        int x1 [1:NUM_LABELS];
        int y0 [1:NUM_LABELS];
        int y1 [1:NUM_LABELS];
        int l, x, y;
        rec_t r;
        exp_ovf = 1'b0;
        for (int i = 1; i <= NUM_LABELS; i++) begin
            ar[i] = 0; x0[i] = 31; x1[i] = 0; y0[i] = 31; y1[i] = 0;
        end
        for (int a = 0; a < 1024; a++) begin
            l = int'(mem[a]);
            x = a % 32;
            y = a / 32;
            if (l > NUM_LABELS) begin
                exp_ovf = 1'b1;
            end else if (l > 0) begin
                ar[l]++;
                if (x < x0[l]) x0[l] = x;
                if (x > x1[l]) x1[l] = x;
                if (y < y0[l]) y0[l] = y;
                if (y > y1[l]) y1[l] = y;
            end
        end
        for (int i = 1; i <= NUM_LABELS; i++) begin
            if (ar[i] > 0) begin
                r.label = 8'(i);
                r.area  = 11'(ar[i]);
`ifdef CLE_STATS_BBOX_EN
                r.xmin = 5'(x0[i]); r.xmax = 5'(x1[i]);
                r.ymin = 5'(y0[i]); r.ymax = 5'(y1[i]);
`else
                r.xmin = 5'd0; r.xmax = 5'd0; r.ymin = 5'd0; r.ymax = 5'd0;
`endif
                sb.push_back(r);
            end
        end
    endtask

    task automatic monitor_records();
        rec_t got, exp;
        forever begin
            @(negedge clk);
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                got = {out_label, out_area, out_xmin, out_xmax, out_ymin, out_ymax};
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL record_unexpected: got %h, expected no record", got);
                end else begin
                    exp = sb.pop_front();
                    if (got !== exp) begin
                        errors++;
                        $display("[TB] FAIL record: got %h, expected %h", got, exp);
                    end
                end
            end
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int c0, output int cyc);
        int c;
        c   = c0;
        cyc = -1;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            c++;
            if (done === 1'b1) begin
                cyc = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({sram_a, out_valid, out_label, out_area} !== 30'd0) begin
            errors++;
            $display("[TB] FAIL reset_out: got %h, expected 0", {sram_a, out_valid, out_label, out_area});
        end
        checks++;
        if ({out_xmin, out_xmax, out_ymin, out_ymax} !== 20'd0) begin
            errors++;
            $display("[TB] FAIL reset_box: got %h, expected 0", {out_xmin, out_xmax, out_ymin, out_ymax});
        end
        checks++;
        if ({busy, done, overflow} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL reset_status: got %b, expected 000", {busy, done, overflow});
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL idle_busy: got %b, expected 0", busy);
        end
    endtask

    task automatic test_zero_map();
        logic ovf;
        int   cyc;
        fill_map(8'd0);
        build_expected(ovf);
        pulse_start();
        checks++;
        if ({busy, sram_a} !== 11'h400) begin
            errors++;
            $display("[TB] FAIL start_busy_addr: got %h, expected 400", {busy, sram_a});
        end
        repeat (1023) @(negedge clk);
        checks++;
        if (sram_a !== 10'd1023) begin
            errors++;
            $display("[TB] FAIL last_addr: got %0d, expected 1023", sram_a);
        end
        wait_done(1023, cyc);
        checks++;
        if (cyc !== LAST_CYC) begin
            errors++;
            $display("[TB] FAIL zero_done_cycle: got %0d, expected %0d", cyc, LAST_CYC);
        end
        checks++;
        if (overflow !== ovf) begin
            errors++;
            $display("[TB] FAIL zero_overflow: got %b, expected %b", overflow, ovf);
        end
        @(negedge clk);
        checks++;
        if ({done, busy} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL done_pulse: got %b, expected 00", {done, busy});
        end
    endtask

    task automatic test_single_pixel();
        logic ovf;
        int   c, first, cyc;
        fill_map(8'd0);
        mem[229] = 8'd3;
        build_expected(ovf);
        pulse_start();
        c = 0;
        first = -1;
        for (int n = 0; n < 1200; n++) begin
            @(negedge clk);
            c++;
            if (out_valid === 1'b1) begin
                first = c;
                break;
            end
        end
        checks++;
        if (first !== 1027) begin
            errors++;
            $display("[TB] FAIL first_valid_cycle: got %0d, expected 1027", first);
        end
        wait_done(c, cyc);
        checks++;
        if (cyc !== LAST_CYC || sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL single_done: got cycle %0d left %0d, expected cycle %0d left 0", cyc, sb.size(), LAST_CYC);
        end
    endtask

    task automatic test_full_map();
        logic ovf;
        int   cyc;
        fill_map(8'd1);
        build_expected(ovf);
        pulse_start();
        wait_done(0, cyc);
        checks++;
        if (cyc !== LAST_CYC || sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL full_done: got cycle %0d left %0d, expected cycle %0d left 0", cyc, sb.size(), LAST_CYC);
        end
    endtask

    task automatic test_back_to_back();
        logic ovf;
        int   c, first, cyc;
        rec_t got;
        fill_map(8'd0);
        mem[0] = 8'd2; mem[40] = 8'd2; mem[500] = 8'd9; mem[1023] = 8'd9;
        build_expected(ovf);
        out_ready = 1'b0;
        pulse_start();
        c = 0;
        first = -1;
        for (int n = 0; n < 1200; n++) begin
            @(negedge clk);
            c++;
            if (out_valid === 1'b1) begin
                first = c;
                break;
            end
        end
        checks++;
        if (first !== 1026 || out_label !== 8'd2) begin
            errors++;
            $display("[TB] FAIL stall_first: got cycle %0d label %0d, expected cycle 1026 label 2", first, out_label);
        end
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            c++;
            got = {out_label, out_area, out_xmin, out_xmax, out_ymin, out_ymax};
            checks++;
            if (out_valid !== 1'b1 || sb.size() == 0 || got !== sb[0]) begin
                errors++;
                $display("[TB] FAIL stall_hold: got valid %b rec %h, expected valid 1 rec %h", out_valid, got, (sb.size() > 0) ? sb[0] : rec_t'(0));
            end
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        wait_done(c, cyc);
        checks++;
        if (cyc !== LAST_CYC + 11 || sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL stall_done: got cycle %0d left %0d, expected cycle %0d left 0", cyc, sb.size(), LAST_CYC + 11);
        end
    endtask

    task automatic test_overflow();
        logic ovf;
        int   cyc;
        fill_map(8'd0);
        mem[100] = 8'd20; mem[101] = 8'd5; mem[1023] = 8'd20;
        build_expected(ovf);
        pulse_start();
        repeat (99) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(100, cyc);
        checks++;
        if (cyc !== LAST_CYC || sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL ovf_done: got cycle %0d left %0d, expected cycle %0d left 0", cyc, sb.size(), LAST_CYC);
        end
        checks++;
        if (overflow !== ovf) begin
            errors++;
            $display("[TB] FAIL overflow_flag: got %b, expected %b", overflow, ovf);
        end
    endtask

    task automatic test_reset_mid_scan();
        logic ovf;
        int   cyc;
        fill_map(8'd4);
        mem[3] = 8'd20;
        pulse_start();
        repeat (300) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, overflow, out_valid, done, sram_a} !== 14'd0) begin
            errors++;
            $display("[TB] FAIL abort_state: got %h, expected 0", {busy, overflow, out_valid, done, sram_a});
        end
        reset = 1'b0;
        fill_map(8'd0);
        mem[1023] = 8'd4; mem[0] = 8'd6;
        build_expected(ovf);
        pulse_start();
        wait_done(0, cyc);
        checks++;
        if (cyc !== LAST_CYC || sb.size() != 0 || overflow !== ovf) begin
            errors++;
            $display("[TB] FAIL rerun: got cycle %0d left %0d ovf %b, expected cycle %0d left 0 ovf %b", cyc, sb.size(), overflow, LAST_CYC, ovf);
        end
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        out_ready = 1'b1;
        fill_map(8'd0);
        fork
            monitor_records();
        join_none
        test_reset();
        test_zero_map();
        test_single_pixel();
        test_full_map();
        test_back_to_back();
        test_overflow();
        test_reset_mid_scan();
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
